// File: rtl/buscaminas_pkg.sv
// Shared board geometry, cursor types and wrap helpers for the Buscaminas board.
package buscaminas_pkg;

  localparam int unsigned FILAS        = 8;
  localparam int unsigned COLUMNAS     = 8;
  localparam int unsigned DEBOUNCE_SIM = 4;

  typedef logic [2:0] pos_t;

  typedef enum logic {
    ESPERA,
    REPITE
  } repeat_state_t;

  function automatic pos_t paso_menos(input pos_t v, input int unsigned n);
    return (v == 3'd0) ? pos_t'(n - 1) : v - 3'd1;
  endfunction

  function automatic pos_t paso_mas(input pos_t v, input int unsigned n);
    return (v == pos_t'(n - 1)) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/boton_antirrebote.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer and
// rising-edge detector on the debounced level.
module boton_antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic nivel,
  output logic pulso
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_nivel;
  logic          r_nivel_d;
  logic [CW-1:0] r_cnt;

  // Counter only runs while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_nivel   <= 1'b0;
      r_nivel_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn_in;
      r_sync2   <= r_sync1;
      r_nivel_d <= r_nivel;
      if (r_sync2 == r_nivel) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_nivel <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign nivel = r_nivel;
  assign pulso = r_nivel & ~r_nivel_d;

endmodule

// File: rtl/cursor_control.sv
// Cursor controller for the 8x8 Buscaminas board: debounced direction buttons
// with auto-repeat move a wrapping cursor; select captures the cursor position.
module cursor_control
  import buscaminas_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned N_FILAS         = FILAS,
  parameter int unsigned N_COLUMNAS      = COLUMNAS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_sel,
  output logic [2:0] fila,
  output logic [2:0] columna,
  output logic       sel_valida,
  output logic [2:0] sel_fila,
  output logic [2:0] sel_columna
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW     = $clog2(REP_MAX + 1);

  // Button index: 0 up, 1 down, 2 left, 3 right, 4 select.
  logic [4:0] w_btn_raw;
  logic [4:0] w_nivel;
  logic [4:0] w_pulso;
  logic [3:0] w_paso;
  logic       w_sel;

  pos_t r_fila;
  pos_t r_columna;
  logic r_sel_valida;
  pos_t r_sel_fila;
  pos_t r_sel_columna;

  assign w_btn_raw = {btn_sel, btn_der, btn_izq, btn_abajo, btn_arriba};

  for (genvar b = 0; b < 5; b++) begin : g_btn
    boton_antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_in(w_btn_raw[b]),
      .nivel (w_nivel[b]),
      .pulso (w_pulso[b])
    );
  end

  // Counter at zero in ESPERA means idle: only a press pulse with enable arms it,
  // so a button already held when enable rises never repeats.
  for (genvar d = 0; d < 4; d++) begin : g_rep
    repeat_state_t  r_estado;
    repeat_state_t  w_estado_sig;
    logic [RCW-1:0] r_cnt;
    logic [RCW-1:0] w_cnt_sig;
    logic           w_tick;
    logic           w_paso_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_estado <= ESPERA;
        r_cnt    <= '0;
      end else begin
        r_estado <= w_estado_sig;
        r_cnt    <= w_cnt_sig;
      end
    end

    always_comb begin
      w_estado_sig = r_estado;
      w_cnt_sig    = r_cnt;
      if (!enable || !w_nivel[d]) begin
        w_estado_sig = ESPERA;
        w_cnt_sig    = '0;
      end else begin
        case (r_estado)
          ESPERA: begin
            if (r_cnt == '0) begin
              if (w_pulso[d]) w_cnt_sig = RCW'(1);
            end else if (r_cnt == RCW'(REPEAT_DELAY)) begin
              w_estado_sig = REPITE;
              w_cnt_sig    = RCW'(1);
            end else begin
              w_cnt_sig = r_cnt + RCW'(1);
            end
          end
          REPITE: begin
            if (r_cnt == RCW'(REPEAT_PERIOD)) w_cnt_sig = RCW'(1);
            else                              w_cnt_sig = r_cnt + RCW'(1);
          end
          default: begin
            w_estado_sig = ESPERA;
            w_cnt_sig    = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_tick = 1'b0;
      case (r_estado)
        ESPERA:  w_tick = (r_cnt == RCW'(REPEAT_DELAY));
        REPITE:  w_tick = (r_cnt == RCW'(REPEAT_PERIOD));
        default: w_tick = 1'b0;
      endcase
      w_paso_d = enable & w_nivel[d] & (w_pulso[d] | w_tick);
    end

    assign w_paso[d] = w_paso_d;
  end

  assign w_sel = enable & w_pulso[4] & w_nivel[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fila        <= '0;
      r_columna     <= '0;
      r_sel_valida  <= 1'b0;
      r_sel_fila    <= '0;
      r_sel_columna <= '0;
    end else begin
      if (w_paso[0] && !w_paso[1])      r_fila <= paso_menos(r_fila, N_FILAS);
      else if (w_paso[1] && !w_paso[0]) r_fila <= paso_mas(r_fila, N_FILAS);

      if (w_paso[2] && !w_paso[3])      r_columna <= paso_menos(r_columna, N_COLUMNAS);
      else if (w_paso[3] && !w_paso[2]) r_columna <= paso_mas(r_columna, N_COLUMNAS);

      r_sel_valida <= w_sel;
      if (w_sel) begin
        r_sel_fila    <= r_fila;
        r_sel_columna <= r_columna;
      end
    end
  end

  assign fila        = r_fila;
  assign columna     = r_columna;
  assign sel_valida  = r_sel_valida;
  assign sel_fila    = r_sel_fila;
  assign sel_columna = r_sel_columna;

endmodule

// File: tb/tb_cursor_control.sv
// Directed bench for cursor_control with short debounce/repeat timing.
module tb_cursor_control;
  import buscaminas_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [4:0] r_btn;
  logic [2:0] fila;
  logic [2:0] columna;
  logic       sel_valida;
  logic [2:0] sel_fila;
  logic [2:0] sel_columna;

  int n_cmp;
  int n_fail;
  int n_pulses;

  cursor_control #(
    .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .N_FILAS        (8),
    .N_COLUMNAS     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn_arriba (r_btn[0]),
    .btn_abajo  (r_btn[1]),
    .btn_izq    (r_btn[2]),
    .btn_der    (r_btn[3]),
    .btn_sel    (r_btn[4]),
    .fila       (fila),
    .columna    (columna),
    .sel_valida (sel_valida),
    .sel_fila   (sel_fila),
    .sel_columna(sel_columna)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int unsigned idx, input int unsigned hold);
    r_btn[idx] = 1'b1;
    tick(hold);
    r_btn[idx] = 1'b0;
    tick(12);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    n_pulses = 0;
    rst      = 1'b0;
    enable   = 1'b1;
    r_btn    = '0;

    tick(3);
    check("rst_fila",    8'(fila),        8'd0);
    check("rst_columna", 8'(columna),     8'd0);
    check("rst_selv",    8'(sel_valida),  8'd0);
    check("rst_self",    8'(sel_fila),    8'd0);
    check("rst_selc",    8'(sel_columna), 8'd0);
    rst = 1'b1;
    tick(2);

    // Clean right press: column steps exactly at 2 + 4 + 1 cycles after the edge.
    r_btn[3] = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("lat_col_k%0d", k), 8'(columna), (k >= 7) ? 8'd1 : 8'd0);
    end
    r_btn[3] = 1'b0;
    tick(12);
    check("lat_fila", 8'(fila), 8'd0);
    check("lat_col_end", 8'(columna), 8'd1);

    // Bouncing down button: 2-cycle toggles never survive the debouncer.
    for (int unsigned i = 0; i < 12; i++) begin
      r_btn[1] = ((i % 4) < 2);
      tick(1);
    end
    check("bounce_mid", 8'(fila), 8'd0);
    r_btn[1] = 1'b1;
    tick(10);
    r_btn[1] = 1'b0;
    tick(12);
    check("bounce_fila", 8'(fila), 8'd1);

    // Wrap-around on both axes.
    press(0, 10);
    check("up_to0", 8'(fila), 8'd0);
    press(0, 10);
    check("wrap_up", 8'(fila), 8'd7);
    press(2, 10);
    press(2, 10);
    check("wrap_left", 8'(columna), 8'd7);
    press(3, 10);
    check("wrap_right", 8'(columna), 8'd0);

    // Auto-repeat: steps land at edges +7, +27, +35, +43, +51, +59.
    r_btn[3] = 1'b1;
    for (int unsigned k = 1; k <= 60; k++) begin
      tick(1);
      if (k == 26) check("rep_k26", 8'(columna), 8'd1);
      if (k == 27) check("rep_k27", 8'(columna), 8'd2);
      if (k == 35) check("rep_k35", 8'(columna), 8'd3);
      if (k == 60) check("rep_k60", 8'(columna), 8'd6);
    end
    r_btn[3] = 1'b0;
    tick(20);
    check("rep_release", 8'(columna), 8'd6);

    // Move to (3,3) then up+down+left together.
    for (int unsigned i = 0; i < 4; i++) press(1, 10);
    for (int unsigned i = 0; i < 3; i++) press(2, 10);
    check("pre_sim_fila", 8'(fila),    8'd3);
    check("pre_sim_col",  8'(columna), 8'd3);
    r_btn[0] = 1'b1;
    r_btn[1] = 1'b1;
    r_btn[2] = 1'b1;
    tick(10);
    r_btn[2:0] = 3'b000;
    tick(12);
    check("sim_fila", 8'(fila),    8'd3);
    check("sim_col",  8'(columna), 8'd2);

    // Select at (5,2).
    press(1, 10);
    press(1, 10);
    r_btn[4] = 1'b1;
    n_pulses = 0;
    for (int unsigned k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 10) r_btn[4] = 1'b0;
      if (sel_valida) n_pulses++;
      if (k == 7) begin
        check("sel_valida", 8'(sel_valida),  8'd1);
        check("sel_fila",   8'(sel_fila),    8'd5);
        check("sel_col",    8'(sel_columna), 8'd2);
      end
      if (k == 8) check("sel_one_cycle", 8'(sel_valida), 8'd0);
    end
    check("sel_count", 8'(n_pulses), 8'd1);

    // enable=0 discards select and moves.
    enable   = 1'b0;
    r_btn[4] = 1'b1;
    r_btn[3] = 1'b1;
    n_pulses = 0;
    for (int unsigned k = 1; k <= 25; k++) begin
      tick(1);
      if (k == 10) r_btn[4:3] = 2'b00;
      if (sel_valida) n_pulses++;
    end
    check("dis_sel_count", 8'(n_pulses), 8'd0);
    check("dis_col",       8'(columna),  8'd2);
    check("dis_self",      8'(sel_fila), 8'd5);

    // Button held across enable rising must not step or repeat.
    r_btn[3] = 1'b1;
    tick(10);
    enable = 1'b1;
    tick(30);
    check("held_en_col", 8'(columna), 8'd2);
    r_btn[3] = 1'b0;
    tick(12);
    check("held_rel_col", 8'(columna), 8'd2);
    press(3, 10);
    check("reen_col", 8'(columna), 8'd3);

    // Reset mid-repeat clears everything asynchronously.
    r_btn[3] = 1'b1;
    tick(30);
    check("pre_rst_col", 8'(columna), 8'd5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_fila", 8'(fila),        8'd0);
    check("arst_col",  8'(columna),     8'd0);
    check("arst_selv", 8'(sel_valida),  8'd0);
    check("arst_self", 8'(sel_fila),    8'd0);
    check("arst_selc", 8'(sel_columna), 8'd0);
    r_btn[3] = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    check("post_rst_col", 8'(columna), 8'd0);
    press(3, 10);
    check("fresh_press_col", 8'(columna), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
